// File: rtl/resample_pkg.sv
// Shared types for the resampler sample-flow scheduler: state encoding,
// mode constants and ratio normalisation.
package resample_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    LATCH  = 3'd2,
    FEED   = 3'd3,
    WAITIN = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  localparam logic MODE_INTERP = 1'b0;
  localparam logic MODE_DECIM  = 1'b1;

  // A ratio of 0 is treated as 1 (pass-through).
  function automatic logic [2:0] norm_ratio(input logic [2:0] r);
    return (r == 3'd0) ? 3'd1 : r;
  endfunction

endpackage

// File: rtl/resample_sched.sv
// Sequences ADC FIFO -> resampler -> DAC FIFO transfers in groups:
// interpolate by N (1 in, N out) or decimate by N (N in, 1 out).
module resample_sched
  import resample_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [2:0]            ratio,
  input  logic                  adc_empty,
  output logic                  adc_rd,
  input  logic [DATA_WIDTH-1:0] adc_rdata,
  output logic                  rs_in_valid,
  output logic [DATA_WIDTH-1:0] rs_in_data,
  input  logic                  rs_in_ready,
  input  logic                  rs_out_valid,
  input  logic [DATA_WIDTH-1:0] rs_out_data,
  output logic                  rs_out_ready,
  input  logic                  dac_full,
  output logic                  dac_wr,
  output logic [DATA_WIDTH-1:0] dac_wdata,
  output logic                  busy,
  output logic [15:0]           wr_count,
  output logic                  err_timeout,
  output state_t                state_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The offering side holds valid and data stable until that edge; ready
  // may be asserted without valid and carries no meaning on its own.

  state_t          state, state_nxt;
  logic            mode_lat;
  logic [2:0]      n_lat;
  logic [2:0]      sub_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            start, in_hs, accept, last_in, last_out, tmo_step, tmo_hit;

  assign adc_rd       = (state == RD);
  assign rs_in_valid  = (state == FEED);
  // Never accept in a write cycle, so dac_full seen here is at most one write stale.
  assign rs_out_ready = (state == DRAIN) && !dac_full && !dac_wr;
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

  assign start    = enable && !adc_empty;
  assign in_hs    = rs_in_valid && rs_in_ready;
  assign accept   = rs_out_valid && rs_out_ready;
  assign last_in  = (mode_lat == MODE_INTERP) || (sub_cnt == n_lat - 3'd1);
  assign last_out = (mode_lat == MODE_DECIM) || (sub_cnt == n_lat - 3'd1);
  // DAC backpressure is not the resampler's fault, so it does not age the timeout.
  assign tmo_step = (state == DRAIN) && !accept && !dac_full;
  assign tmo_hit  = tmo_step && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD;
      RD:      state_nxt = LATCH;
      LATCH:   state_nxt = FEED;
      FEED:    if (in_hs) state_nxt = last_in ? DRAIN : WAITIN;
      WAITIN:  if (!adc_empty) state_nxt = RD;
      DRAIN:   if ((accept && last_out) || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_lat    <= MODE_INTERP;
      n_lat       <= 3'd1;
      sub_cnt     <= '0;
      tmo_cnt     <= '0;
      rs_in_data  <= '0;
      dac_wr      <= 1'b0;
      dac_wdata   <= '0;
      wr_count    <= '0;
      err_timeout <= 1'b0;
    end else begin
      dac_wr <= accept;
      if (accept) begin
        dac_wdata <= rs_out_data;
        wr_count  <= wr_count + 16'd1;
      end
      if (tmo_hit) err_timeout <= 1'b1;
      case (state)
        IDLE: if (start) begin
          mode_lat <= mode;
          n_lat    <= norm_ratio(ratio);
          sub_cnt  <= '0;
        end
        LATCH: rs_in_data <= adc_rdata;
        FEED: if (in_hs) begin
          sub_cnt <= last_in ? 3'd0 : sub_cnt + 3'd1;
          tmo_cnt <= '0;
        end
        DRAIN: begin
          if (accept) begin
            sub_cnt <= sub_cnt + 3'd1;
            tmo_cnt <= '0;
          end else if (tmo_step) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_resample_sched.sv
// Directed bench for resample_sched with behavioural ADC FIFO, resampler and
// DAC FIFO models around the DUT.
module tb_resample_sched;
  import resample_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         mode = 1'b0;
  logic [2:0]   ratio = 3'd1;
  logic         adc_empty = 1'b1;
  logic         adc_rd;
  logic [W-1:0] adc_rdata = '0;
  logic         rs_in_valid;
  logic [W-1:0] rs_in_data;
  logic         rs_in_ready = 1'b1;
  logic         rs_out_valid = 1'b0;
  logic [W-1:0] rs_out_data = '0;
  logic         rs_out_ready;
  logic         dac_full = 1'b0;
  logic         dac_wr;
  logic [W-1:0] dac_wdata;
  logic         busy;
  logic [15:0]  wr_count;
  logic         err_timeout;
  state_t       state_dbg;

  resample_sched #(.DATA_WIDTH(W), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .ratio(ratio),
    .adc_empty(adc_empty), .adc_rd(adc_rd), .adc_rdata(adc_rdata),
    .rs_in_valid(rs_in_valid), .rs_in_data(rs_in_data), .rs_in_ready(rs_in_ready),
    .rs_out_valid(rs_out_valid), .rs_out_data(rs_out_data), .rs_out_ready(rs_out_ready),
    .dac_full(dac_full), .dac_wr(dac_wr), .dac_wdata(dac_wdata),
    .busy(busy), .wr_count(wr_count), .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  // Clock/reset
  always #5 clk = ~clk;

  // Environment state
  logic [W-1:0] adc_q[$];
  logic [W-1:0] out_q[$];
  logic [W-1:0] got_q[$];
  int           model_n = 1;
  bit           model_decim = 1'b0;
  bit           rs_out_en = 1'b1;
  bit           out_pend;
  logic [W-1:0] dec_sum;
  int           dec_cnt;
  int           adc_rd_cnt, in_hs_cnt, waitin_cnt, b2b_cnt, rdy_wr_cnt, rdy_full_cnt;
  bit           prev_wr;
  state_t       prev_state;
  int           n_checks = 0;
  int           n_errors = 0;

  // Models and monitors act on the falling edge; stimulus changes just after
  // the rising edge, so neither races the DUT nor each other.
  always @(negedge clk) begin
    if (adc_rd && !reset) begin
      adc_rd_cnt++;
      if (adc_q.size() > 0) adc_rdata = adc_q.pop_front();
    end
    adc_empty = (adc_q.size() == 0);
    if (dac_wr) got_q.push_back(dac_wdata);
    if (dac_wr && prev_wr) b2b_cnt++;
    if (rs_out_ready && dac_wr) rdy_wr_cnt++;
    if (rs_out_ready && dac_full) rdy_full_cnt++;
    if (state_dbg == WAITIN && prev_state != WAITIN) waitin_cnt++;
    prev_wr = dac_wr;
    prev_state = state_dbg;
    if (out_pend) begin
      if (out_q.size() > 0) out_q.delete(0);
      out_pend = 1'b0;
    end
    if (rs_in_valid && rs_in_ready && !reset) begin
      in_hs_cnt++;
      if (!model_decim) begin
        for (int k = 0; k < model_n; k++) out_q.push_back(rs_in_data + W'(k));
      end else begin
        dec_sum = dec_sum + rs_in_data;
        dec_cnt++;
        if (dec_cnt == model_n) begin
          out_q.push_back(dec_sum);
          dec_sum = '0;
          dec_cnt = 0;
        end
      end
    end
    rs_out_valid = rs_out_en && (out_q.size() > 0);
    rs_out_data  = rs_out_valid ? out_q[0] : '0;
    if (rs_out_valid && rs_out_ready && !reset) out_pend = 1'b1;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_env();
    adc_q.delete(); out_q.delete(); got_q.delete();
    out_pend = 1'b0; dec_sum = '0; dec_cnt = 0; prev_wr = 1'b0;
    adc_rd_cnt = 0; in_hs_cnt = 0; waitin_cnt = 0;
    b2b_cnt = 0; rdy_wr_cnt = 0; rdy_full_cnt = 0;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset = 1'b1;
    tick(2);
    clear_env();
    model_n = 1; model_decim = 1'b0; rs_out_en = 1'b1;
    rs_in_ready = 1'b1; dac_full = 1'b0; mode = MODE_INTERP; ratio = 3'd1;
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) tick(1);
  endtask

  task automatic wait_state(input state_t s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state_dbg == s) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_checks++; if ({adc_rd, rs_in_valid, rs_out_ready, dac_wr, busy, err_timeout} !== 6'b0) begin n_errors++; $display("FAIL reset_ctrl: got %b want 000000", {adc_rd, rs_in_valid, rs_out_ready, dac_wr, busy, err_timeout}); end
    n_checks++; if (wr_count !== 16'd0) begin n_errors++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    n_checks++; if ({rs_in_data, dac_wdata} !== '0) begin n_errors++; $display("FAIL reset_data: got %h/%h want 0/0", rs_in_data, dac_wdata); end
    n_checks++; if (state_dbg !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
  endtask

  task automatic test_min_latency();
    do_reset();
    adc_q.push_back(32'hA5A5A5A5);
    enable = 1'b1;                                    // t0: IDLE
    tick(1);                                          // t1: RD
    enable = 1'b0;
    n_checks++; if ({adc_rd, busy} !== 2'b11) begin n_errors++; $display("FAIL lat_t1_rd: got %b want 11", {adc_rd, busy}); end
    tick(1);                                          // t2: LATCH
    n_checks++; if ({adc_rd, rs_in_valid} !== 2'b00) begin n_errors++; $display("FAIL lat_t2_latch: got %b want 00", {adc_rd, rs_in_valid}); end
    tick(1);                                          // t3: FEED
    n_checks++; if (rs_in_valid !== 1'b1 || rs_in_data !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL lat_t3_feed: got %b/%h want 1/a5a5a5a5", rs_in_valid, rs_in_data); end
    tick(1);                                          // t4: DRAIN
    n_checks++; if ({rs_out_ready, dac_wr} !== 2'b10) begin n_errors++; $display("FAIL lat_t4_drain: got %b want 10", {rs_out_ready, dac_wr}); end
    tick(1);                                          // t5: write
    n_checks++; if (dac_wr !== 1'b1 || dac_wdata !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL lat_t5_wr: got %b/%h want 1/a5a5a5a5", dac_wr, dac_wdata); end
    n_checks++; if (wr_count !== 16'd1 || busy !== 1'b0) begin n_errors++; $display("FAIL lat_t5_count: got %0d/%b want 1/0", wr_count, busy); end
  endtask

  task automatic test_interp4();
    logic [W-1:0] exp_w [12] = '{32'h11111111, 32'h11111112, 32'h11111113, 32'h11111114,
                                 32'h22222222, 32'h22222223, 32'h22222224, 32'h22222225,
                                 32'h33333333, 32'h33333334, 32'h33333335, 32'h33333336};
    do_reset();
    model_n = 4;
    adc_q.push_back(32'h11111111); adc_q.push_back(32'h22222222); adc_q.push_back(32'h33333333);
    mode = MODE_INTERP; ratio = 3'd4; enable = 1'b1;
    wait_writes(12, 300);
    enable = 1'b0;
    tick(4);
    n_checks++; if (got_q.size() !== 12) begin n_errors++; $display("FAIL interp_wr_n: got %0d want 12", got_q.size()); end
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_w[i]) begin n_errors++; $display("FAIL interp_data[%0d]: got %h want %h", i, got_q[i], exp_w[i]); end
    end
    n_checks++; if (adc_rd_cnt !== 3) begin n_errors++; $display("FAIL interp_adc_rd: got %0d want 3", adc_rd_cnt); end
    n_checks++; if (wr_count !== 16'd12) begin n_errors++; $display("FAIL interp_wr_count: got %0d want 12", wr_count); end
    n_checks++; if (b2b_cnt !== 0 || rdy_wr_cnt !== 0) begin n_errors++; $display("FAIL interp_spacing: got b2b=%0d rdy_wr=%0d want 0/0", b2b_cnt, rdy_wr_cnt); end
  endtask

  task automatic test_decim2();
    logic [W-1:0] exp_w [3] = '{32'h30, 32'h70, 32'hB0};
    do_reset();
    model_decim = 1'b1; model_n = 2;
    for (int i = 1; i <= 6; i++) adc_q.push_back(W'(i * 16));
    mode = MODE_DECIM; ratio = 3'd2; enable = 1'b1;
    wait_writes(3, 300);
    enable = 1'b0;
    tick(4);
    n_checks++; if (got_q.size() !== 3) begin n_errors++; $display("FAIL decim_wr_n: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_w[i]) begin n_errors++; $display("FAIL decim_data[%0d]: got %h want %h", i, got_q[i], exp_w[i]); end
    end
    n_checks++; if (in_hs_cnt !== 6) begin n_errors++; $display("FAIL decim_in_hs: got %0d want 6", in_hs_cnt); end
    n_checks++; if (waitin_cnt !== 3) begin n_errors++; $display("FAIL decim_waitin: got %0d want 3", waitin_cnt); end
    n_checks++; if (adc_rd_cnt !== 6 || wr_count !== 16'd3) begin n_errors++; $display("FAIL decim_counts: got rd=%0d wr=%0d want 6/3", adc_rd_cnt, wr_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    model_n = 2; dac_full = 1'b1;
    adc_q.push_back(32'h100);
    mode = MODE_INTERP; ratio = 3'd2; enable = 1'b1;
    tick(1);
    enable = 1'b0;
    wait_state(DRAIN, 20, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL bp_reach_drain: got state %0d want %0d", state_dbg, DRAIN); end
    tick(20);
    n_checks++; if (state_dbg !== DRAIN || err_timeout !== 1'b0) begin n_errors++; $display("FAIL bp_no_timeout: got state=%0d err=%b want %0d/0", state_dbg, err_timeout, DRAIN); end
    n_checks++; if (rdy_full_cnt !== 0 || got_q.size() !== 0) begin n_errors++; $display("FAIL bp_stalled: got rdy_full=%0d writes=%0d want 0/0", rdy_full_cnt, got_q.size()); end
    dac_full = 1'b0;
    wait_writes(2, 50);
    tick(3);
    n_checks++; if (got_q.size() !== 2) begin n_errors++; $display("FAIL bp_wr_n: got %0d want 2", got_q.size()); end
    n_checks++; if (got_q.size() == 2 && (got_q[0] !== 32'h100 || got_q[1] !== 32'h101)) begin n_errors++; $display("FAIL bp_data: got %h %h want 100 101", got_q[0], got_q[1]); end
    n_checks++; if (b2b_cnt !== 0 || rdy_wr_cnt !== 0) begin n_errors++; $display("FAIL bp_spacing: got b2b=%0d rdy_wr=%0d want 0/0", b2b_cnt, rdy_wr_cnt); end
    n_checks++; if (busy !== 1'b0 || err_timeout !== 1'b0) begin n_errors++; $display("FAIL bp_done: got busy=%b err=%b want 0/0", busy, err_timeout); end
  endtask

  task automatic test_timeout();
    bit ok;
    int drain_cycles;
    do_reset();
    rs_out_en = 1'b0;
    adc_q.push_back(32'hDEAD0001);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    wait_state(DRAIN, 20, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL tmo_reach_drain: got state %0d want %0d", state_dbg, DRAIN); end
    drain_cycles = 0;
    while (state_dbg == DRAIN && drain_cycles < 100) begin drain_cycles++; tick(1); end
    n_checks++; if (drain_cycles !== 15) begin n_errors++; $display("FAIL tmo_cycles: got %0d want 15", drain_cycles); end
    n_checks++; if (busy !== 1'b0 || err_timeout !== 1'b1) begin n_errors++; $display("FAIL tmo_abort: got busy=%b err=%b want 0/1", busy, err_timeout); end
    tick(5);
    n_checks++; if (err_timeout !== 1'b1 || got_q.size() !== 0 || wr_count !== 16'd0) begin n_errors++; $display("FAIL tmo_sticky: got err=%b writes=%0d cnt=%0d want 1/0/0", err_timeout, got_q.size(), wr_count); end
    do_reset();
    n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL tmo_clear: got %b want 0", err_timeout); end
  endtask

  task automatic test_ratio();
    bit ok;
    do_reset();
    adc_q.push_back(32'h55);
    mode = MODE_INTERP; ratio = 3'd0; enable = 1'b1;
    tick(1);
    enable = 1'b0;
    wait_writes(1, 30);
    tick(3);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== 32'h55) begin n_errors++; $display("FAIL ratio0_pass: got n=%0d d=%h want 1/55", got_q.size(), got_q.size() > 0 ? got_q[0] : 32'h0); end
    n_checks++; if (in_hs_cnt !== 1 || busy !== 1'b0) begin n_errors++; $display("FAIL ratio0_in: got hs=%0d busy=%b want 1/0", in_hs_cnt, busy); end
    do_reset();
    model_n = 4;
    adc_q.push_back(32'h200);
    mode = MODE_INTERP; ratio = 3'd4; enable = 1'b1;
    wait_state(RD, 10, ok);
    ratio = 3'd2; mode = MODE_DECIM; enable = 1'b0;
    adc_q.push_back(32'h300);
    wait_writes(4, 80);
    tick(6);
    n_checks++; if (got_q.size() !== 4) begin n_errors++; $display("FAIL ratio_latched_n: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== 32'h200 + W'(i)) begin n_errors++; $display("FAIL ratio_latched_data[%0d]: got %h want %h", i, got_q[i], 32'h200 + W'(i)); end
    end
    n_checks++; if (adc_rd_cnt !== 1 || busy !== 1'b0) begin n_errors++; $display("FAIL enable_low_stop: got rd=%0d busy=%b want 1/0", adc_rd_cnt, busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    rs_in_ready = 1'b0;
    adc_q.push_back(32'hAAA); adc_q.push_back(32'hBBB);
    enable = 1'b1;
    wait_state(FEED, 20, ok);
    enable = 1'b0;
    n_checks++; if (!ok || rs_in_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_feed: got valid=%b want 1", rs_in_valid); end
    reset = 1'b1;
    tick(1);
    n_checks++; if ({adc_rd, rs_in_valid, rs_out_ready, dac_wr, busy} !== 5'b0) begin n_errors++; $display("FAIL rstmid_ctrl: got %b want 00000", {adc_rd, rs_in_valid, rs_out_ready, dac_wr, busy}); end
    n_checks++; if (rs_in_data !== '0 || dac_wdata !== '0) begin n_errors++; $display("FAIL rstmid_data: got %h/%h want 0/0", rs_in_data, dac_wdata); end
    reset = 1'b0; rs_in_ready = 1'b1;
    tick(1);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    wait_writes(1, 30);
    tick(3);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== 32'hBBB) begin n_errors++; $display("FAIL rstmid_restart: got n=%0d d=%h want 1/bbb", got_q.size(), got_q.size() > 0 ? got_q[0] : 32'h0); end
    n_checks++; if (wr_count !== 16'd1 || adc_rd_cnt !== 2) begin n_errors++; $display("FAIL rstmid_counts: got wr=%0d rd=%0d want 1/2", wr_count, adc_rd_cnt); end
  endtask

  initial begin
    clear_env();
    test_reset();
    test_min_latency();
    test_interp4();
    test_decim2();
    test_backpressure();
    test_timeout();
    test_ratio();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
